window_gen_3x3: RTL

- Upstream feeder for the 3x3 Gaussian convolution stage.
- Accepts a raster-order pixel stream, one pixel per handshake, row-major, top-left first.
- Keeps the two previous image rows in line buffers and presents complete 3x3 neighbourhoods on nine 8-bit window ports, wired one-to-one to the convolver's pixel_00..pixel_22 inputs.
- Emits valid-only windows: no edge padding. A 4x4 frame yields exactly 2x2 windows.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/line_buffer.sv | 39 +++
 rtl/window_gen_3x3.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// ============================================================================
// Module : conv_pkg
// Brief  : Shared types and constants for the 3x3 convolution front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int PIX_W     = 8;
    localparam int K         = 3;
    localparam int IMG_W_DEF = 4;
    localparam int IMG_H_DEF = 4;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [K-1:0][K-1:0] window_t;

endpackage

`default_nettype wire

// File: rtl/line_buffer.sv
// ============================================================================
// Module : line_buffer
// Brief  : One image row of storage, asynchronous read, read-before-write.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module line_buffer #(
    parameter  int DEPTH = conv_pkg::IMG_W_DEF,
    parameter  int WIDTH = conv_pkg::PIX_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read is combinational from the pre-edge contents, so a same-address
    // write on this edge is seen only by the next access.
    assign rdata = mem_q[addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/window_gen_3x3.sv
// ============================================================================
// Module : window_gen_3x3
// Brief  : Raster pixel stream to valid-only 3x3 neighbourhoods.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module window_gen_3x3 #(
    parameter  int IMG_W = conv_pkg::IMG_W_DEF,
    parameter  int IMG_H = conv_pkg::IMG_H_DEF,
    parameter  int PIX_W = conv_pkg::PIX_W,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] pixel_00,
    output logic [PIX_W-1:0] pixel_01,
    output logic [PIX_W-1:0] pixel_02,
    output logic [PIX_W-1:0] pixel_10,
    output logic [PIX_W-1:0] pixel_11,
    output logic [PIX_W-1:0] pixel_12,
    output logic [PIX_W-1:0] pixel_20,
    output logic [PIX_W-1:0] pixel_21,
    output logic [PIX_W-1:0] pixel_22,
    output logic [RW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic             out_last,
    output logic             frame_done
);

    localparam int            K      = conv_pkg::K;
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic [PIX_W-1:0] hist_q [K][K-1];
    logic [PIX_W-1:0] hist_d [K][K-1];
    logic [PIX_W-1:0] win_q  [K][K];
    logic [PIX_W-1:0] win_d  [K][K];
    logic [PIX_W-1:0] new_col [K];
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [RW-1:0]    out_row_q, out_row_d;
    logic [CW-1:0]    out_col_q, out_col_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_done_q, frame_done_d;
    logic             acc, emit;

    assign in_ready = !out_valid_q || out_ready;
    assign acc      = in_valid && in_ready;
    // A start-of-frame pixel is placed at (0,0) regardless of the counters.
    assign cur_col  = in_sof ? '0 : col_q;
    assign cur_row  = in_sof ? '0 : row_q;
    assign emit     = acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    assign new_col[0] = lb1_rd;
    assign new_col[1] = lb0_rd;
    assign new_col[2] = in_pixel;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .rst   (rst),
        .we    (acc),
        .addr  (cur_col),
        .wdata (in_pixel),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .rst   (rst),
        .we    (acc),
        .addr  (cur_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hist_d       = hist_q;
        win_d        = win_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        out_valid_d  = out_valid_q && !out_ready;

        if (acc) begin
            // The newest column is the live input; only the older K-1 are stored.
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 2; j++) begin
                    hist_d[i][j] = hist_q[i][j+1];
                end
                hist_d[i][K-2] = new_col[i];
            end
            if (cur_col == C_LAST) begin
                col_d = '0;
                row_d = (cur_row == R_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            frame_done_d = (cur_col == C_LAST) && (cur_row == R_LAST);
        end

        if (emit) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[i][j] = hist_q[i][j];
                end
                win_d[i][K-1] = new_col[i];
            end
            out_row_d   = cur_row;
            out_col_d   = cur_col;
            out_last_d  = frame_done_d;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    hist_q[i][j] <= '0;
                end
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            hist_q       <= hist_d;
            win_q        <= win_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign pixel_00   = win_q[0][0];
    assign pixel_01   = win_q[0][1];
    assign pixel_02   = win_q[0][2];
    assign pixel_10   = win_q[1][0];
    assign pixel_11   = win_q[1][1];
    assign pixel_12   = win_q[1][2];
    assign pixel_20   = win_q[2][0];
    assign pixel_21   = win_q[2][1];
    assign pixel_22   = win_q[2][2];

endmodule

`default_nettype wire
